store_checker: RTL and testbench

Self-checking store monitor that sits directly downstream of the `top` processor/memory pair and consumes its `memwrite`/`dataadr`/`writedata` outputs. It judges each data-memory store against a pass signature and an allowed-address set, and latches a sticky PASS/FAIL/TIMEOUT verdict. This replaces the simulation-only negedge checker so the same self-test runs on the FPGA, where only a few status pins are driven. An optional trace FIFO records every store for readout.

---
 rtl/store_checker.sv | 144 ++++++++++++++
 tb/tb_store_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_checker.sv
// rtl/store_checker.sv - store verdict monitor; optional trace FIFO built when STORE_CHECKER_TRACE_EN is defined
module store_checker #(
  parameter logic [7:0]  PASS_ADR  = 8'd84,
  parameter logic [31:0] PASS_DATA = 32'd7,
  parameter logic [7:0]  ALLOW_ADR = 8'd80,
  parameter int          TIMEOUT   = 4096,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memwrite,
  input  logic [7:0]  dataadr,
  input  logic [31:0] writedata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [15:0] store_count,
  output logic [15:0] cycle_count,
  input  logic        trace_rd,
  output logic        trace_valid,
  output logic [7:0]  trace_adr,
  output logic [31:0] trace_data,
  output logic        trace_ovf
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

  state_t state;
  logic   in_run;
  logic   store;

  assign in_run = (state == ST_RUN);
  assign store  = in_run && memwrite;

  // Verdict FSM: judge each RUN store, time out when idle too long, latch the verdict
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_RUN;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else if (in_run) begin
      if (memwrite) begin
        if ((dataadr == PASS_ADR) && (writedata == PASS_DATA)) begin
          state <= ST_PASS;
          done  <= 1'b1;
          pass  <= 1'b1;
        end else if (dataadr != ALLOW_ADR) begin
          state <= ST_FAIL;
          done  <= 1'b1;
          fail  <= 1'b1;
        end
      end else if (cycle_count == TO_LAST) begin
        state   <= ST_TIMEOUT;
        done    <= 1'b1;
        timeout <= 1'b1;
      end
    end
  end

  // Saturating activity counters, frozen once a verdict is latched
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      store_count <= '0;
      cycle_count <= '0;
    end else if (in_run) begin
      if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
      if (memwrite && (store_count != 16'hFFFF)) store_count <= store_count + 16'd1;
    end
  end

`ifdef STORE_CHECKER_TRACE_EN
  localparam int AW = $clog2(DEPTH);

  logic [39:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count;
  logic [AW:0]   count_after_pop;
  logic [AW:0]   count_next;
  logic          pop;
  logic          full;
  logic          push_ok;

  // A pop in the same cycle frees the slot a full-FIFO push needs
  always_comb begin
    pop             = trace_rd && (count != '0);
    full            = (count == (AW+1)'(DEPTH));
    push_ok         = store && (!full || pop);
    rd_next         = rd_ptr + AW'(pop);
    count_after_pop = count - (AW+1)'(pop);
    count_next      = count_after_pop + (AW+1)'(push_ok);
  end

  // Entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (reset_n && push_ok) mem[wr_ptr] <= {dataadr, writedata};
  end

  // Pointers, occupancy, overflow flag and the registered first-word-fall-through head
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      trace_ovf   <= 1'b0;
      trace_valid <= 1'b0;
      trace_adr   <= '0;
      trace_data  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      if (store && !push_ok) trace_ovf <= 1'b1;
      if (count_next == '0) begin
        trace_valid <= 1'b0;
        trace_adr   <= '0;
        trace_data  <= '0;
      end else if (count_after_pop == '0) begin
        trace_valid <= 1'b1;
        trace_adr   <= dataadr;
        trace_data  <= writedata;
      end else begin
        trace_valid <= 1'b1;
        {trace_adr, trace_data} <= mem[rd_next];
      end
    end
  end
`else
  logic unused_trace_rd;

  assign unused_trace_rd = trace_rd;
  assign trace_valid     = 1'b0;
  assign trace_adr       = '0;
  assign trace_data      = '0;
  assign trace_ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// tb/tb_store_checker.sv - directed self-checking bench for store_checker
module tb_store_checker;

  logic        clk;
  logic        reset_n;
  logic        memwrite;
  logic [7:0]  dataadr;
  logic [31:0] writedata;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [15:0] store_count;
  logic [15:0] cycle_count;
  logic        trace_rd;
  logic        trace_valid;
  logic [7:0]  trace_adr;
  logic [31:0] trace_data;
  logic        trace_ovf;

  int vectors;
  int miscompares;

  store_checker #(
    .PASS_ADR (8'd84),
    .PASS_DATA(32'd7),
    .ALLOW_ADR(8'd80),
    .TIMEOUT  (16),
    .DEPTH    (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .store_count(store_count),
    .cycle_count(cycle_count),
    .trace_rd   (trace_rd),
    .trace_valid(trace_valid),
    .trace_adr  (trace_adr),
    .trace_data (trace_data),
    .trace_ovf  (trace_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic chk_verdict(input string tag, input logic d, input logic p, input logic f, input logic t);
    chk(tag, {28'd0, done, pass, fail, timeout}, {28'd0, d, p, f, t});
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [7:0] a, input logic [31:0] d);
`ifdef STORE_CHECKER_TRACE_EN
    chk({tag, "_valid"}, {31'd0, trace_valid}, {31'd0, v});
    chk({tag, "_adr"}, {24'd0, trace_adr}, {24'd0, a});
    chk({tag, "_data"}, trace_data, d);
`else
    chk({tag, "_tied"}, {23'd0, trace_valid, trace_adr}, 32'd0);
    chk({tag, "_tdata"}, trace_data, 32'd0);
`endif
  endtask

  task automatic chk_ovf(input string tag, input logic o);
`ifdef STORE_CHECKER_TRACE_EN
    chk(tag, {31'd0, trace_ovf}, {31'd0, o});
`else
    chk(tag, {31'd0, trace_ovf}, 32'd0);
`endif
  endtask

  task automatic cyc(input logic mw, input logic [7:0] adr, input logic [31:0] dat, input logic rd, input logic rn);
    memwrite  = mw;
    dataadr   = adr;
    writedata = dat;
    trace_rd  = rd;
    reset_n   = rn;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
    trace_rd  = 1'b0;
    reset_n   = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    cyc(1'b0, 8'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    memwrite    = 1'b0;
    dataadr     = '0;
    writedata   = '0;
    trace_rd    = 1'b0;
    @(negedge clk);

    // reset state
    do_reset();
    chk_verdict("rst_verdict", 0, 0, 0, 0);
    chk("rst_store_count", {16'd0, store_count}, 32'd0);
    chk("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
    chk_head("rst_head", 0, 8'd0, 32'd0);
    chk_ovf("rst_ovf", 0);

    // allowed store then passing store
    cyc(1'b1, 8'd80, 32'd5, 1'b0, 1'b1);
    chk_verdict("allow_verdict", 0, 0, 0, 0);
    chk("allow_store_count", {16'd0, store_count}, 32'd1);
    chk("allow_cycle_count", {16'd0, cycle_count}, 32'd1);
    chk_head("allow_head", 1, 8'd80, 32'd5);
    cyc(1'b1, 8'd84, 32'd7, 1'b0, 1'b1);
    chk_verdict("pass_verdict", 1, 1, 0, 0);
    chk("pass_store_count", {16'd0, store_count}, 32'd2);
    chk("pass_cycle_count", {16'd0, cycle_count}, 32'd2);
    chk_head("pass_head", 1, 8'd80, 32'd5);
    cyc(1'b0, 8'd0, 32'd0, 1'b1, 1'b1);
    chk_head("pop1_head", 1, 8'd84, 32'd7);
    chk("pass_cycle_hold", {16'd0, cycle_count}, 32'd2);
    cyc(1'b0, 8'd0, 32'd0, 1'b1, 1'b1);
    chk_head("pop2_head", 0, 8'd0, 32'd0);
    cyc(1'b1, 8'd88, 32'd1, 1'b0, 1'b1);
    chk_verdict("pass_sticky", 1, 1, 0, 0);
    chk("pass_ignored_store", {16'd0, store_count}, 32'd2);
    chk_head("pass_no_trace", 0, 8'd0, 32'd0);

    // wrong data at the pass address
    do_reset();
    cyc(1'b1, 8'd84, 32'd6, 1'b0, 1'b1);
    chk_verdict("baddata_verdict", 1, 0, 1, 0);
    chk("baddata_store_count", {16'd0, store_count}, 32'd1);
    cyc(1'b1, 8'd84, 32'd7, 1'b0, 1'b1);
    chk_verdict("fail_sticky", 1, 0, 1, 0);
    chk("fail_store_count", {16'd0, store_count}, 32'd1);

    // disallowed address
    do_reset();
    cyc(1'b1, 8'd88, 32'd7, 1'b0, 1'b1);
    chk_verdict("badadr_verdict", 1, 0, 1, 0);

    // timeout after 16 idle RUN edges
    do_reset();
    idle(15);
    chk_verdict("pre_timeout", 0, 0, 0, 0);
    chk("pre_timeout_cycles", {16'd0, cycle_count}, 32'd15);
    idle(1);
    chk_verdict("timeout_verdict", 1, 0, 0, 1);
    chk("timeout_cycles", {16'd0, cycle_count}, 32'd16);
    idle(2);
    chk("timeout_cycles_hold", {16'd0, cycle_count}, 32'd16);
    chk_verdict("timeout_sticky", 1, 0, 0, 1);

    // a store on the timeout edge takes precedence
    do_reset();
    idle(15);
    cyc(1'b1, 8'd84, 32'd7, 1'b0, 1'b1);
    chk_verdict("store_beats_timeout", 1, 1, 0, 0);
    chk("store_beats_cycles", {16'd0, cycle_count}, 32'd16);
    chk("store_beats_count", {16'd0, store_count}, 32'd1);

    // nine stores without pops overflow an 8-entry FIFO
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'd80, 32'(i), 1'b0, 1'b1);
    chk("ovf_store_count", {16'd0, store_count}, 32'd9);
    chk_ovf("ovf_set", 1);
    for (int i = 0; i < 8; i++) begin
      chk_head($sformatf("ovf_entry%0d", i), 1, 8'd80, 32'(i));
      cyc(1'b0, 8'd0, 32'd0, 1'b1, 1'b1);
    end
    chk_head("ovf_drained", 0, 8'd0, 32'd0);
    cyc(1'b0, 8'd0, 32'd0, 1'b1, 1'b1);
    chk_head("pop_empty_ignored", 0, 8'd0, 32'd0);
    chk_ovf("ovf_sticky", 1);

    // pop on the ninth store makes room for it
    do_reset();
    chk_ovf("ovf_cleared", 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'd80, 32'(i), 1'b0, 1'b1);
    cyc(1'b1, 8'd80, 32'd8, 1'b1, 1'b1);
    chk_ovf("full_pop_push_no_ovf", 0);
    for (int i = 1; i < 9; i++) begin
      chk_head($sformatf("popfull_entry%0d", i), 1, 8'd80, 32'(i));
      cyc(1'b0, 8'd0, 32'd0, 1'b1, 1'b1);
    end
    chk_head("popfull_drained", 0, 8'd0, 32'd0);

    // reset mid-run beats a simultaneous bad store
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd80, 32'(i + 10), 1'b0, 1'b1);
    chk("midrst_pre_count", {16'd0, store_count}, 32'd3);
    cyc(1'b1, 8'd88, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk_verdict("midrst_verdict", 0, 0, 0, 0);
    chk("midrst_store_count", {16'd0, store_count}, 32'd0);
    chk("midrst_cycle_count", {16'd0, cycle_count}, 32'd0);
    chk_head("midrst_head", 0, 8'd0, 32'd0);
    chk_ovf("midrst_ovf", 0);
    cyc(1'b1, 8'd84, 32'd7, 1'b0, 1'b1);
    chk_verdict("midrst_then_pass", 1, 1, 0, 0);
    chk("midrst_then_count", {16'd0, store_count}, 32'd1);
    chk_head("midrst_then_head", 1, 8'd84, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
